// File: rtl/axi_sram_pkg.sv
// Shared widths, response codes and FSM state types for the AXI SRAM slave.
package axi_sram_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // Only single-beat bursts are serviced; anything longer is answered with SLVERR.
    function automatic logic [RESP_W-1:0] len_resp(input logic [LEN_W-1:0] len);
        return (len == '0) ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word-wide SRAM array: one synchronous read port, one byte-strobed write port.
// A read and a write to the same word on the same edge return the old data.
module axi_sram_mem
    import axi_sram_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic              aclk,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb
);

    logic [DATA_W-1:0] mem [2**AW];

    // Registered read and byte-lane write; contents are never reset.
    always_ff @(posedge aclk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-outstanding AXI slave in front of a word SRAM. Independent read and
// write FSMs, programmable response latency, single-beat transfers only.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int unsigned MEM_AW = 12,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned WR_LAT = 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [RESP_W-1:0] rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [RESP_W-1:0] bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam logic [2:0] RD_LAST = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);
    localparam logic [2:0] WR_LAST = (WR_LAT == 0) ? 3'd0 : 3'(WR_LAT - 1);

    logic                  out_of_reset;

    // Read side
    r_state_t              r_state;
    logic [2:0]            r_cnt;
    logic [ID_W-1:0]       r_id;
    logic [MEM_AW-1:0]     r_addr;
    logic [RESP_W-1:0]     r_resp;
    logic                  ar_hs;
    logic                  rd_en;
    logic [MEM_AW-1:0]     rd_addr;
    logic [DATA_W-1:0]     mem_rdata;

    // Write side
    w_state_t              w_state;
    logic [2:0]            w_cnt;
    logic                  aw_got;
    logic                  w_got;
    logic [ID_W-1:0]       w_id;
    logic [MEM_AW-1:0]     w_addr;
    logic [RESP_W-1:0]     w_resp;
    logic [DATA_W-1:0]     w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  both_got;
    logic                  commit;
    logic                  wr_en;
    logic [ID_W-1:0]       cur_id;
    logic [RESP_W-1:0]     cur_resp;
    logic [MEM_AW-1:0]     cur_addr;
    logic [DATA_W-1:0]     cur_data;
    logic [STRB_W-1:0]     cur_strb;

    // Address bits outside the word index, and the W-channel id/last, carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{araddr[ADDR_W-1:MEM_AW+2], araddr[1:0],
                           awaddr[ADDR_W-1:MEM_AW+2], awaddr[1:0], wid, wlast};

    // Readies stay low until the first clock edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
        end
    end

    assign arready = (r_state == R_IDLE) && out_of_reset;
    assign ar_hs   = arvalid && arready;

    // Memory read strobe fires on the edge that enters R_RESP; with zero latency
    // that is the AR handshake edge itself, so the live address is used.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = r_addr;
        if (r_state == R_IDLE) begin
            rd_addr = araddr[MEM_AW+1:2];
            rd_en   = ar_hs && (RD_LAT == 0);
        end else if (r_state == R_WAIT) begin
            rd_en   = (r_cnt == RD_LAST);
        end
    end

    // Read FSM with registered R-channel outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_resp  <= '0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rresp   <= '0;
            rlast   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_id   <= arid;
                        r_addr <= araddr[MEM_AW+1:2];
                        r_resp <= len_resp(arlen);
                        r_cnt  <= '0;
                        if (RD_LAT == 0) begin
                            r_state <= R_RESP;
                            rvalid  <= 1'b1;
                            rid     <= arid;
                            rresp   <= len_resp(arlen);
                            rlast   <= 1'b1;
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt == RD_LAST) begin
                        r_state <= R_RESP;
                        rvalid  <= 1'b1;
                        rid     <= r_id;
                        rresp   <= r_resp;
                        rlast   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_state <= R_IDLE;
                        rvalid  <= 1'b0;
                        rid     <= '0;
                        rresp   <= '0;
                        rlast   <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // The memory output register only moves on rd_en, so it holds through a stall;
    // error responses and idle cycles present zero.
    assign rdata = (rvalid && (rresp == RESP_OKAY)) ? mem_rdata : '0;

    assign awready  = (w_state == W_IDLE) && !aw_got && out_of_reset;
    assign wready   = (w_state == W_IDLE) && !w_got && out_of_reset;
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign both_got = (aw_got || aw_hs) && (w_got || w_hs);

    // Commit takes captured fields, or the live bus values when they arrive on the
    // commit edge itself (only possible with zero write latency).
    always_comb begin
        cur_id   = aw_got ? w_id   : awid;
        cur_resp = aw_got ? w_resp : len_resp(awlen);
        cur_addr = aw_got ? w_addr : awaddr[MEM_AW+1:2];
        cur_data = w_got  ? w_data : wdata;
        cur_strb = w_got  ? w_strb : wstrb;
        commit   = ((w_state == W_IDLE) && both_got && (WR_LAT == 0)) ||
                   ((w_state == W_WAIT) && (w_cnt == WR_LAST));
        wr_en    = commit && (cur_resp == RESP_OKAY);
    end

    // Write FSM: collects AW and W in any order, then waits, commits and responds.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            w_id    <= '0;
            w_addr  <= '0;
            w_resp  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_got <= 1'b1;
                        w_id   <= awid;
                        w_addr <= awaddr[MEM_AW+1:2];
                        w_resp <= len_resp(awlen);
                    end
                    if (w_hs) begin
                        w_got  <= 1'b1;
                        w_data <= wdata;
                        w_strb <= wstrb;
                    end
                    if (both_got) begin
                        w_cnt <= '0;
                        if (WR_LAT == 0) begin
                            w_state <= W_RESP;
                            bvalid  <= 1'b1;
                            bid     <= cur_id;
                            bresp   <= cur_resp;
                        end else begin
                            w_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt == WR_LAST) begin
                        w_state <= W_RESP;
                        bvalid  <= 1'b1;
                        bid     <= w_id;
                        bresp   <= w_resp;
                    end else begin
                        w_cnt <= w_cnt + 3'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                        bvalid  <= 1'b0;
                        bid     <= '0;
                        bresp   <= '0;
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    axi_sram_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .aclk    (aclk),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (mem_rdata),
        .wr_en   (wr_en),
        .wr_addr (cur_addr),
        .wr_data (cur_data),
        .wr_strb (cur_strb)
    );

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter MEM_AW, default 12, log2 of memory depth in 32-bit words.
REQ-002 Parameter RD_LAT, default 1, extra read cycles from AR acceptance to first rvalid, range 0..7.
REQ-003 Parameter WR_LAT, default 1, extra cycles from AW+W capture to bvalid, range 0..7.
REQ-004 aclk  in  1  single clock; aresetn  in  1  asynchronous active-low reset.
REQ-005 arid/araddr/arlen  in  4/32/8  read request ID, byte address, beat count-1; arvalid in 1, arready out 1  AR handshake.
REQ-006 rid/rdata/rresp/rlast  out  4/32/2/1  read response; rvalid out 1, rready in 1  R handshake.
REQ-007 awid/awaddr/awlen  in  4/32/8  write request; awvalid in 1, awready out 1  AW handshake.
REQ-008 wid/wdata/wstrb/wlast  in  4/32/4/1  write data, byte lanes; wvalid in 1, wready out 1  W handshake.
REQ-009 bid/bresp  out  4/2  write response; bvalid out 1, bready in 1  B handshake.

Function
REQ-010 Read FSM states R_IDLE, R_WAIT, R_RESP; arready = (R_IDLE and out_of_reset).
REQ-011 AR handshake at edge T: capture arid, araddr[MEM_AW+1:2], arlen; R_IDLE -> R_WAIT, or -> R_RESP directly when RD_LAT = 0.
REQ-012 R_WAIT counts RD_LAT cycles; rvalid first high in cycle T+1+RD_LAT; rdata sampled from memory on the edge entering R_RESP and held stable until handshake.
REQ-013 R_RESP: rvalid = 1, rid = captured arid, rlast = 1; rresp = 00 (OKAY) if captured arlen = 0, else 10 (SLVERR) with rdata = 0; single beat always.
REQ-014 rvalid and rready at edge: R_RESP -> R_IDLE; next AR accepted no earlier than the following cycle (one read outstanding).
REQ-015 Write FSM states W_IDLE, W_WAIT, W_RESP; in W_IDLE awready = ~aw_got, wready = ~w_got (each gated by out_of_reset), AW and W accepted independently in any order or same cycle.
REQ-016 Once aw_got and w_got both set: -> W_WAIT (or commit immediately when WR_LAT = 0); after WR_LAT cycles, commit write and enter W_RESP on the same edge.
REQ-017 Commit writes wdata byte lane i iff wstrb[i]; wstrb = 0 leaves memory unchanged; commit skipped when awlen != 0.
REQ-018 W_RESP: bvalid = 1, bid = captured awid, bresp = 00 if awlen = 0 else 10; bvalid and bready -> W_IDLE, clear aw_got/w_got.
REQ-019 Address bits above MEM_AW+1 ignored (aliasing wrap); bits [1:0] ignored.
REQ-020 Read sample and write commit to same word on same edge: read returns pre-write data.
REQ-021 rvalid/bvalid, once high, held with response fields stable until handshake regardless of new requests.
REQ-022 Read and write FSMs fully independent; no ID reordering, no outstanding beyond one per direction.

Reset
REQ-023 aresetn low: immediately force R_IDLE, W_IDLE, counters 0, aw_got/w_got 0, out_of_reset 0; all outputs 0, including readies.
REQ-024 out_of_reset set on first aclk edge with aresetn high; readies rise the cycle after.
REQ-025 Reset mid-transaction drops it silently; no response issued; memory contents retained (not reset).

Structure
REQ-026 Package axi_sram_pkg holds ID/addr/data/len/strb/resp widths, RESP_OKAY = 00, RESP_SLVERR = 10, state encodings.
REQ-027 Sub-module axi_sram_mem: 2^MEM_AW x 32 array, one synchronous read port, one byte-strobe write port, read-before-write.

Verification
REQ-028 RD_LAT = 1: write 0xDEADBEEF to 0x100, then AR 0x100 id 1 at T -> rvalid at T+2, rdata 0xDEADBEEF, rid 1, rresp 00, rlast 1.
REQ-029 W before AW by 3 cycles, wstrb 0011, wdata 0x1234ABCD over 0xFFFFFFFF -> bvalid after AW+1+WR_LAT, readback 0xFFFFABCD.
REQ-030 rready held low 5 cycles -> rvalid/rdata/rid stable all 5 cycles, arready low until 1 cycle after handshake.
REQ-031 arlen = 3 -> single beat, rresp 10, rdata 0, rlast 1; awlen = 1 -> bresp 10, memory unchanged.
REQ-032 Same-edge read sample and commit to 0x40 (old 0x1, new 0x2) -> rdata 0x1; next read -> 0x2.
REQ-033 aresetn pulsed low during R_WAIT and W_WAIT -> rvalid/bvalid never assert, readies 0 during reset, prior data at 0x100 still readable.
